// File: rtl/dot_frame_buffer.sv
`timescale 1ns/1ps
// Double-buffered dot list for a VGA overlay: the processor fills the back bank,
// a commit publishes it at the next frame boundary, and isDot scans the front bank.
module dot_frame_buffer #(
    parameter  int DOT_COUNT = 16,
    localparam int AW        = $clog2(DOT_COUNT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wEn,
    input  logic [AW-1:0] wAddr,
    input  logic [31:0]   wData,
    input  logic          commit,
    input  logic          screenEnd,
    input  logic [9:0]    x,
    input  logic [8:0]    y,
    output logic          wReady,
    output logic          isDot,
    output logic [7:0]    frameCount,
    output logic          swapped
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] SWAP    = 2'd2;

    logic [1:0]           state;
    logic                 front;
    logic                 back_sel;
    logic [DOT_COUNT-1:0] valid [2];
    logic [9:0]           slot_x [2][DOT_COUNT];
    logic [8:0]           slot_y [2][DOT_COUNT];
    logic                 se_prev;
    logic                 se_armed;
    logic                 s_edge;
    logic                 hit;
    logic                 unused_bits;

    assign back_sel    = ~front;
    assign wReady      = (state == IDLE);
    assign swapped     = (state == SWAP);
    assign unused_bits = ^{wData[30:25], wData[15:10]};

    // se_armed blocks a spurious boundary when screenEnd is already high as reset releases.
    assign s_edge = screenEnd & ~se_prev & se_armed;

    // NOTE: every variable driven here gets a default first so no latch is inferred.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DOT_COUNT; i++) begin
            if (valid[front][i] && slot_x[front][i] == x && slot_y[front][i] == y)
                hit = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            front      <= 1'b0;
            valid[0]   <= '0;
            valid[1]   <= '0;
            se_prev    <= 1'b0;
            se_armed   <= 1'b0;
            frameCount <= 8'd0;
            isDot      <= 1'b0;
        end else begin
            se_prev  <= screenEnd;
            se_armed <= se_armed | ~screenEnd;
            isDot    <= hit;
            if (s_edge)
                frameCount <= frameCount + 8'd1;

            case (state)
                IDLE: begin
                    if (wEn)
                        valid[back_sel][wAddr] <= wData[31];
                    if (commit)
                        state <= PENDING;
                end
                PENDING: begin
                    if (s_edge)
                        state <= SWAP;
                end
                SWAP: begin
                    // The outgoing front becomes the new back bank and starts empty.
                    front        <= ~front;
                    valid[front] <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: coordinate storage is not reset; the valid bits alone decide what is visible.
    always_ff @(posedge clk) begin
        if (state == IDLE && wEn) begin
            slot_x[back_sel][wAddr] <= wData[9:0];
            slot_y[back_sel][wAddr] <= wData[24:16];
        end
    end

endmodule

// File: tb/tb_dot_frame_buffer.sv
`timescale 1ns/1ps
// Self-checking bench for dot_frame_buffer: a bank-copy reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_dot_frame_buffer;

    localparam int N  = 16;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wEn = 1'b0;
    logic [AW-1:0] wAddr = '0;
    logic [31:0]   wData = '0;
    logic          commit = 1'b0;
    logic          screenEnd = 1'b0;
    logic [9:0]    x = '0;
    logic [8:0]    y = '0;
    logic          wReady;
    logic          isDot;
    logic [7:0]    frameCount;
    logic          swapped;

    int n_cmp  = 0;
    int n_fail = 0;
    int swap_cnt = 0;

    dot_frame_buffer #(.DOT_COUNT(N)) dut (
        .clk(clk), .reset(reset), .wEn(wEn), .wAddr(wAddr), .wData(wData),
        .commit(commit), .screenEnd(screenEnd), .x(x), .y(y),
        .wReady(wReady), .isDot(isDot), .frameCount(frameCount), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Reference model: the front and back banks are plain lists that get copied on a swap.
    bit         fv [N];
    logic [9:0] fx [N];
    logic [8:0] fy [N];
    bit         bv [N];
    logic [9:0] bx [N];
    logic [8:0] by [N];
    bit         m_pending = 0;
    bit         m_swap = 0;
    bit         m_prev = 0;
    bit         m_armed = 0;
    bit         m_dot = 0;
    logic [7:0] m_fc = 8'd0;

    function automatic bit front_hit(input logic [9:0] px, input logic [8:0] py);
        for (int i = 0; i < N; i++)
            if (fv[i] && fx[i] == px && fy[i] == py) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pending = 0; m_swap = 0; m_prev = 0; m_armed = 0; m_dot = 0; m_fc = 8'd0;
            for (int i = 0; i < N; i++) begin fv[i] = 0; bv[i] = 0; end
        end else begin
            bit edge_now;
            edge_now = screenEnd && !m_prev && m_armed;
            m_dot = front_hit(x, y);
            if (edge_now) m_fc = m_fc + 8'd1;
            if (m_swap) begin
                for (int i = 0; i < N; i++) begin
                    fv[i] = bv[i]; fx[i] = bx[i]; fy[i] = by[i];
                    bv[i] = 0;
                end
                m_swap = 0;
            end else if (m_pending) begin
                if (edge_now) begin m_pending = 0; m_swap = 1; end
            end else begin
                if (wEn) begin
                    bv[wAddr] = wData[31]; bx[wAddr] = wData[9:0]; by[wAddr] = wData[24:16];
                end
                if (commit) m_pending = 1;
            end
            m_prev  = screenEnd;
            m_armed = m_armed || !screenEnd;
        end
    end

    always @(negedge clk) begin
        check("wReady", wReady, !m_pending && !m_swap);
        check("isDot", isDot, m_dot);
        check("frameCount", frameCount, m_fc);
        check("swapped", swapped, m_swap);
        if (swapped) swap_cnt++;
    end

    // Inputs change 1 ns after the falling edge, clear of both the compare and the active edge.
    task automatic tick();
        @(posedge clk); @(negedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
    endtask

    task automatic write_slot(input int a, input bit vis, input int px, input int py);
        wEn = 1'b1; wAddr = AW'(a);
        wData = {vis, 6'h2a, 9'(py), 6'h15, 10'(px)};
        tick();
        wEn = 1'b0;
    endtask

    task automatic do_commit();
        commit = 1'b1; tick(); commit = 1'b0;
    endtask

    task automatic pulse_se(input int n);
        screenEnd = 1'b1;
        repeat (n) tick();
        screenEnd = 1'b0;
        tick();
    endtask

    task automatic present(input int px, input int py, input bit exp, input string name);
        x = 10'(px); y = 9'(py);
        tick();
        check(name, isDot, exp);
    endtask

    logic [9:0] pool_x [8];
    logic [8:0] pool_y [8];

    initial begin
        int base;
        int se_left;
        int k;
        do_reset();
        check("reset_wready", wReady, 1'b1);
        check("reset_fc", frameCount, 8'd0);
        check("reset_isdot", isDot, 1'b0);

        // Basic publish and hit.
        write_slot(3, 1, 310, 50);
        do_commit();
        check("pending_wready", wReady, 1'b0);
        base = swap_cnt;
        pulse_se(4);
        check("swap_once", swap_cnt - base, 1);
        check("fc_one", frameCount, 8'd1);
        present(310, 50, 1'b1, "hit_310_50");
        present(311, 50, 1'b0, "miss_311_50");

        // Writes while pending are dropped.
        do_commit();
        check("pend_block_wready", wReady, 1'b0);
        write_slot(0, 1, 100, 200);
        pulse_se(2);
        present(100, 200, 1'b0, "dropped_write");
        present(310, 50, 1'b0, "old_front_gone");

        // Write and commit in the same cycle.
        wEn = 1'b1; wAddr = AW'(1); wData = {1'b1, 6'h3f, 9'd0, 6'h3f, 10'd0}; commit = 1'b1;
        tick();
        wEn = 1'b0; commit = 1'b0;
        pulse_se(2);
        present(0, 0, 1'b1, "same_cycle_hit");

        // Old front is cleared when it becomes the back bank.
        write_slot(2, 1, 639, 479);
        do_commit();
        pulse_se(2);
        present(639, 479, 1'b1, "corner_hit");
        do_commit();
        pulse_se(2);
        present(639, 479, 1'b0, "corner_cleared");

        // Visible=0 clears a slot; last write wins.
        write_slot(4, 1, 20, 30);
        write_slot(4, 1, 21, 30);
        write_slot(5, 1, 40, 41);
        write_slot(5, 0, 40, 41);
        do_commit();
        pulse_se(2);
        present(21, 30, 1'b1, "last_write_wins");
        present(20, 30, 1'b0, "overwritten");
        present(40, 41, 1'b0, "invisible_slot");

        // 256 frame boundaries with no commit.
        do_reset();
        base = swap_cnt;
        repeat (256) pulse_se(2);
        check("fc_wrap", frameCount, 8'd0);
        check("no_swap_256", swap_cnt - base, 0);

        // Reset in PENDING with screenEnd high across release.
        do_commit();
        base = swap_cnt;
        reset = 1'b1; screenEnd = 1'b1;
        tick();
        check("wready_in_reset", wReady, 1'b1);
        tick();
        reset = 1'b0;
        tick(); tick();
        check("no_edge_after_reset", frameCount, 8'd0);
        check("wready_after_reset", wReady, 1'b1);
        screenEnd = 1'b0; tick();
        pulse_se(2);
        check("fc_after_abort", frameCount, 8'd1);
        check("no_swap_after_abort", swap_cnt - base, 0);

        // Randomized traffic checked by the model every cycle.
        pool_x[0] = 10'd639; pool_y[0] = 9'd479;
        pool_x[1] = 10'd0;   pool_y[1] = 9'd0;
        for (int i = 2; i < 8; i++) begin
            pool_x[i] = 10'($urandom_range(0, 639));
            pool_y[i] = 9'($urandom_range(0, 479));
        end
        se_left = 3;
        for (int c = 0; c < 3000; c++) begin
            if (se_left == 0) begin
                screenEnd = ~screenEnd;
                se_left = $urandom_range(2, 8);
            end
            se_left--;
            k = $urandom_range(0, 7);
            wEn   = 1'($urandom_range(0, 1));
            wAddr = AW'($urandom_range(0, N - 1));
            wData = {($urandom_range(0, 3) != 0), 6'($urandom), pool_y[k], 6'($urandom), pool_x[k]};
            commit = ($urandom_range(0, 15) == 0);
            k = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) begin
                x = pool_x[k]; y = pool_y[k];
            end else begin
                x = 10'($urandom_range(0, 639)); y = 9'($urandom_range(0, 479));
            end
            reset = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; wEn = 1'b0; commit = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
